dmem_access_ctrl: RTL

Memory-stage load/store initiator for the 32-bit pipelined CPU. It accepts load and store operations carried by the `_d2` pipeline signals and drives a registered request/acknowledge port toward the data memory, which may respond with variable latency. While an access is outstanding it stalls the pipeline, and it returns load data as a registered, one-cycle-qualified result. It also flags out-of-range addresses and memory-response timeouts.

---
 rtl/dmem_access_ctrl_if.sv | 34 +++
 rtl/dmem_access_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_access_ctrl_if
//  Description : Request/acknowledge bus between the memory-stage load/store
//                initiator (master) and the data memory (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_access_ctrl
//  Description : Memory-stage load/store initiator. Issues a registered
//                request toward a variable-latency data memory, stalls the
//                pipeline while an access is outstanding, returns load data
//                as a one-cycle-qualified result, and flags out-of-range
//                addresses and response timeouts.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_access_ctrl #(
    parameter logic [5:0] LOAD_OP  = 6'b000100,
    parameter logic [5:0] STORE_OP = 6'b000101,
    parameter int         DEPTH    = 11,
    parameter int         TIMEOUT  = 15
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               valid_d2,
    input  wire logic [5:0]         opcode_d2,
    input  wire logic [31:0]        alu_out_d2,
    input  wire logic [31:0]        reg_rs1_d2,
    output      logic               stall,
    output      logic [31:0]        load_data,
    output      logic               load_valid,
    output      logic               addr_err,
    output      logic               timeout_err,
    dmem_access_ctrl_if.master      mem
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    // Wait counter compares against TIMEOUT-1 so the request is held for
    // exactly TIMEOUT cycles before the access is abandoned.
    localparam logic [3:0] c_WAIT_LAST = 4'(TIMEOUT - 1);
    localparam logic [31:0] c_DEPTH    = 32'(DEPTH);

    logic [0:0]  state_q;
    logic [0:0]  state_d;
    logic [3:0]  wait_cnt_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] load_data_q;
    logic        load_valid_q;
    logic        addr_err_q;
    logic        timeout_err_q;

    logic        w_mem_op;
    logic        w_in_range;
    logic        w_idle;
    logic        w_busy;
    logic        w_accept;
    logic        w_out_of_range;
    logic        w_ack_hit;
    logic        w_timeout_hit;

    assign w_mem_op       = valid_d2 && ((opcode_d2 == LOAD_OP) || (opcode_d2 == STORE_OP));
    assign w_in_range     = (alu_out_d2 < c_DEPTH);
    assign w_idle         = (state_q == c_IDLE);
    assign w_busy         = (state_q == c_BUSY);
    assign w_accept       = w_idle && w_mem_op && w_in_range;
    assign w_out_of_range = w_idle && w_mem_op && !w_in_range;
    // Ack is only honoured while a request is outstanding.
    assign w_ack_hit      = w_busy && mem.mem_ack;
    assign w_timeout_hit  = w_busy && !mem.mem_ack && (wait_cnt_q == c_WAIT_LAST);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: IDLE -> BUSY on accept, BUSY -> IDLE on ack or timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: if (w_accept) state_d = c_BUSY;
            c_BUSY: if (w_ack_hit || w_timeout_hit) state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // FSM outputs: hold the pipeline on accept and while waiting for an ack
    always_comb begin
        stall = 1'b0;
        case (state_q)
            c_IDLE:  stall = w_accept;
            c_BUSY:  stall = !mem.mem_ack && !w_timeout_hit;
            default: stall = 1'b0;
        endcase
    end

    // Wait counter: cleared on accept, counts every unacknowledged BUSY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 4'd0;
        end else if (w_accept) begin
            wait_cnt_q <= 4'd0;
        end else if (w_busy && !mem.mem_ack) begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
        end
    end

    // Request attributes are captured once on accept and stay stable while BUSY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
        end else if (w_accept) begin
            mem_we_q    <= (opcode_d2 == STORE_OP);
            mem_addr_q  <= alu_out_d2;
            mem_wdata_q <= reg_rs1_d2;
        end
    end

    // Load result: capture read data on a load ack, pulse the qualifier once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_data_q  <= 32'd0;
            load_valid_q <= 1'b0;
        end else begin
            load_valid_q <= w_ack_hit && !mem_we_q;
            if (w_ack_hit && !mem_we_q) begin
                load_data_q <= mem.mem_rdata;
            end
        end
    end

    // Error flags: address error is a one-cycle pulse, timeout is sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            addr_err_q <= w_out_of_range;
            if (w_timeout_hit) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    // The request line is simply the BUSY state, which is itself a flop
    assign mem.mem_req   = w_busy;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    assign load_data   = load_data_q;
    assign load_valid  = load_valid_q;
    assign addr_err    = addr_err_q;
    assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire
